// File: rtl/can_tx_frame.sv
// CAN 2.0A standard data frame transmitter: serializes SOF through IFS with
// CRC-15 generation and bit stuffing; one frame per accepted request.
module can_tx_frame #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_req,
    input  logic [10:0] tx_id,
    input  logic [3:0]  tx_dlc,
    input  logic [63:0] tx_data,
    input  logic        rx,
    output logic        tx,
    output logic        tx_ready,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        ack_err,
    output logic [14:0] crc_out
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [14:0] CRC_POLY = 15'h4599;

    typedef enum logic [3:0] {
        S_IDLE, S_SOF, S_ID, S_CTRL, S_DATA, S_CRC,
        S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_IFS
    } state_t;

    state_t        state, state_d, adv_state;
    logic [TW-1:0] tick, tick_d;
    logic [6:0]    idx, idx_d, adv_idx, data_last;
    logic [2:0]    run_len, run_len_d;
    logic          stuff_now, stuff_now_d;
    logic [14:0]   crc, crc_d, crc_upd, crc_feed;
    logic          tx_d, ack_err_d, adv_bit, wrap, stuff_zone, crc_zone;
    logic [10:0]   id_q, id_d;
    logic [3:0]    dlc_q, dlc_d;
    logic [63:0]   data_q, data_d;
    logic [6:0]    ctrl_bits;

    assign wrap       = (tick == TICK_LAST);
    assign stuff_zone = state inside {S_SOF, S_ID, S_CTRL, S_DATA, S_CRC};
    assign crc_zone   = state inside {S_SOF, S_ID, S_CTRL, S_DATA};
    assign ctrl_bits  = {3'b000, dlc_q};
    assign data_last  = dlc_q[3] ? 7'd63 : ({1'b0, dlc_q[2:0], 3'b000} - 7'd1);
    assign crc_upd    = {crc[13:0], 1'b0} ^ ((tx ^ crc[14]) ? CRC_POLY : 15'h0);
    // The CRC field's first bit must already include the last data bit's update
    assign crc_feed   = (crc_zone && wrap && !stuff_now) ? crc_upd : crc;

    assign tx_ready = (state == S_IDLE);
    assign tx_busy  = (state != S_IDLE);
    assign tx_done  = (state == S_IFS) && (idx == 7'd2) && wrap;
    assign crc_out  = crc;

    // Next non-stuff bit position and level after the current one
    always_comb begin
        adv_state = state;
        adv_idx   = idx + 7'd1;
        adv_bit   = 1'b1;
        case (state)
            S_SOF: begin
                adv_state = S_ID; adv_idx = '0; adv_bit = id_q[10];
            end
            S_ID:
                if (idx == 7'd10) begin
                    adv_state = S_CTRL; adv_idx = '0; adv_bit = 1'b0;
                end else adv_bit = id_q[4'd9 - idx[3:0]];
            S_CTRL:
                if (idx == 7'd6) begin
                    adv_idx = '0;
                    if (dlc_q == 4'd0) begin
                        adv_state = S_CRC; adv_bit = crc_feed[14];
                    end else begin
                        adv_state = S_DATA; adv_bit = data_q[63];
                    end
                end else adv_bit = ctrl_bits[3'd5 - idx[2:0]];
            S_DATA:
                if (idx == data_last) begin
                    adv_state = S_CRC; adv_idx = '0; adv_bit = crc_feed[14];
                end else adv_bit = data_q[6'd62 - idx[5:0]];
            S_CRC:
                if (idx == 7'd14) begin
                    adv_state = S_CRC_DEL; adv_idx = '0;
                end else adv_bit = crc[4'd13 - idx[3:0]];
            S_CRC_DEL: begin adv_state = S_ACK;     adv_idx = '0; end
            S_ACK:     begin adv_state = S_ACK_DEL; adv_idx = '0; end
            S_ACK_DEL: begin adv_state = S_EOF;     adv_idx = '0; end
            S_EOF:
                if (idx == 7'd6) begin adv_state = S_IFS; adv_idx = '0; end
            S_IFS:
                if (idx == 7'd2) begin adv_state = S_IDLE; adv_idx = '0; end
            default: begin adv_state = S_IDLE; adv_idx = '0; end
        endcase
    end

    always_comb begin
        state_d     = state;
        tick_d      = tick;
        idx_d       = idx;
        run_len_d   = run_len;
        stuff_now_d = stuff_now;
        crc_d       = crc;
        tx_d        = tx;
        ack_err_d   = 1'b0;
        id_d        = id_q;
        dlc_d       = dlc_q;
        data_d      = data_q;
        if (state == S_IDLE) begin
            tick_d = '0;
            if (tx_req) begin
                state_d     = S_SOF;
                idx_d       = '0;
                tx_d        = 1'b0;
                run_len_d   = 3'd1;
                stuff_now_d = 1'b0;
                crc_d       = '0;
                id_d        = tx_id;
                dlc_d       = tx_dlc;
                data_d      = tx_data;
            end
        end else begin
            tick_d = wrap ? '0 : tick + TW'(1);
            if (wrap) begin
                crc_d = crc_feed;
                if (state == S_ACK) ack_err_d = rx;
                // Stuff bits hold the field position; the following real bit resumes it
                if (stuff_zone && !stuff_now && run_len == 3'd5) begin
                    tx_d        = ~tx;
                    run_len_d   = 3'd1;
                    stuff_now_d = 1'b1;
                end else begin
                    state_d     = adv_state;
                    idx_d       = adv_idx;
                    tx_d        = adv_bit;
                    stuff_now_d = 1'b0;
                    run_len_d   = (adv_bit == tx) ? run_len + 3'd1 : 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tick      <= '0;
            idx       <= '0;
            run_len   <= '0;
            stuff_now <= 1'b0;
            crc       <= '0;
            tx        <= 1'b1;
            ack_err   <= 1'b0;
            id_q      <= '0;
            dlc_q     <= '0;
            data_q    <= '0;
        end else begin
            state     <= state_d;
            tick      <= tick_d;
            idx       <= idx_d;
            run_len   <= run_len_d;
            stuff_now <= stuff_now_d;
            crc       <= crc_d;
            tx        <= tx_d;
            ack_err   <= ack_err_d;
            id_q      <= id_d;
            dlc_q     <= dlc_d;
            data_q    <= data_d;
        end
    end
endmodule

// File: tb/tb_can_tx_frame.sv
// Bench for can_tx_frame: two instances (1 and 4 clks/bit) checked against a
// list-based frame model, destuffed CRC residue and handshake timing.
module tb_can_tx_frame;
    typedef bit bq_t[$];

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]        req, rxv, txo, rdy, bsy, dne, aerr;
    logic [1:0][10:0]  idv;
    logic [1:0][3:0]   dlcv;
    logic [1:0][63:0]  datav;
    logic [1:0][14:0]  crco;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    can_tx_frame #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_req(req[0]), .tx_id(idv[0]), .tx_dlc(dlcv[0]),
        .tx_data(datav[0]), .rx(rxv[0]), .tx(txo[0]), .tx_ready(rdy[0]), .tx_busy(bsy[0]),
        .tx_done(dne[0]), .ack_err(aerr[0]), .crc_out(crco[0]));

    can_tx_frame #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .tx_req(req[1]), .tx_id(idv[1]), .tx_dlc(dlcv[1]),
        .tx_data(datav[1]), .rx(rxv[1]), .tx(txo[1]), .tx_ready(rdy[1]), .tx_busy(bsy[1]),
        .tx_done(dne[1]), .ack_err(aerr[1]), .crc_out(crco[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] crc15(input bq_t bits);
        logic [14:0] c = '0;
        logic nxt;
        foreach (bits[i]) begin
            nxt = bits[i] ^ c[14];
            c = {c[13:0], 1'b0};
            if (nxt) c = c ^ 15'h4599;
        end
        return c;
    endfunction

    // Whole frame as seen on the wire: fields, CRC, stuffing, then 13 recessive bits
    function automatic void model(input logic [10:0] id, input logic [3:0] dlc,
                                  input logic [63:0] data, output bq_t frame,
                                  output logic [14:0] c);
        bq_t raw;
        int nb, run;
        bit last;
        raw = {};
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        repeat (3) raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nb = (dlc > 8) ? 8 : int'(dlc);
        for (int i = 0; i < nb * 8; i++) raw.push_back(data[63 - i]);
        c = crc15(raw);
        for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
        frame = {};
        run = 0;
        last = 1'b0;
        foreach (raw[i]) begin
            frame.push_back(raw[i]);
            if (run > 0 && raw[i] == last) run++; else run = 1;
            last = raw[i];
            if (run == 5) begin
                frame.push_back(!last);
                last = !last;
                run = 1;
            end
        end
        repeat (13) frame.push_back(1'b1);
    endfunction

    task automatic check_idle(input int w, input string tag);
        chk({tag, "_tx"}, txo[w], 1);
        chk({tag, "_ready"}, rdy[w], 1);
        chk({tag, "_busy"}, bsy[w], 0);
        chk({tag, "_done"}, dne[w], 0);
        chk({tag, "_ackerr"}, aerr[w], 0);
        chk({tag, "_crc"}, crco[w], 0);
    endtask

    // Called at a negedge with instance w idle; returns at its SOF negedge
    task automatic start(input int w, input logic [10:0] id, input logic [3:0] dlc,
                         input logic [63:0] data);
        idv[w] = id; dlcv[w] = dlc; datav[w] = data; req[w] = 1'b1;
        @(negedge clk);
        chk("accept_busy", bsy[w], 1);
        chk("accept_ready", rdy[w], 0);
        chk("sof", txo[w], 0);
    endtask

    task automatic scramble(input int w);
        req[w] = 1'b0;
        idv[w] = 11'($urandom);
        dlcv[w] = 4'($urandom);
        datav[w] = {$urandom, $urandom};
    endtask

    task automatic do_frame(input int w, input logic [10:0] id, input logic [3:0] dlc,
                            input logic [63:0] data, input bit ack_on, output bq_t got);
        bq_t exp, samp, ds;
        logic [14:0] mcrc;
        int cpb, n, done_n, done_idx, ack_n, ack_idx, hold_err, mism, skip_err, nraw, run, nb;
        bit tmo, last, skip;
        cpb = (w == 0) ? 1 : 4;
        model(id, dlc, data, exp, mcrc);
        samp = {};
        n = 0; done_n = 0; done_idx = -1; ack_n = 0; ack_idx = -1; tmo = 0;
        while (bsy[w]) begin
            if (ack_on)
                rxv[w] = (n >= (exp.size() - 12) * cpb && n < (exp.size() - 11) * cpb) ? 1'b0 : 1'b1;
            else
                rxv[w] = 1'b1;
            samp.push_back(txo[w]);
            if (dne[w]) begin done_n++; done_idx = n; end
            if (aerr[w]) begin ack_n++; ack_idx = n; end
            n++;
            if (n > 3000) begin tmo = 1; break; end
            @(negedge clk);
        end
        rxv[w] = 1'b1;
        chk("timeout", tmo, 0);
        got = {};
        hold_err = 0;
        for (int k = 0; k * cpb < samp.size(); k++) begin
            got.push_back(samp[k * cpb]);
            for (int j = 1; j < cpb; j++)
                if (k * cpb + j >= samp.size() || samp[k * cpb + j] != samp[k * cpb]) hold_err++;
        end
        chk("len", samp.size(), exp.size() * cpb);
        mism = 0;
        for (int k = 0; k < exp.size(); k++)
            if (k >= got.size() || got[k] != exp[k]) mism++;
        chk("bits", mism, 0);
        chk("hold", hold_err, 0);
        chk("done_cnt", done_n, 1);
        chk("done_pos", done_idx, exp.size() * cpb - 1);
        chk("ack_cnt", ack_n, ack_on ? 0 : 1);
        if (!ack_on) chk("ack_pos", ack_idx, (exp.size() - 11) * cpb);
        chk("crc_out", crco[w], mcrc);
        chk("ready_after", rdy[w], 1);
        // Independent view: destuff the wire and check the CRC residue is zero
        nb = (dlc > 8) ? 8 : int'(dlc);
        nraw = 34 + 8 * nb;
        ds = {}; run = 0; skip = 0; last = 0; skip_err = 0;
        for (int i = 0; i < got.size() && ds.size() < nraw; i++) begin
            if (skip) begin
                if (got[i] == last) skip_err++;
                last = got[i]; run = 1; skip = 0;
            end else begin
                ds.push_back(got[i]);
                if (run > 0 && got[i] == last) run++; else run = 1;
                last = got[i];
                if (run == 5) skip = 1;
            end
        end
        chk("destuff_len", ds.size(), nraw);
        chk("stuff_polarity", skip_err, 0);
        chk("residue", crc15(ds), 0);
        if (ds.size() >= 19) chk("dlc_field", {ds[15], ds[16], ds[17], ds[18]}, dlc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        bq_t got;
        logic [21:0] pat;
        logic [10:0] ida, idb;
        logic [63:0] da, db;
        logic [3:0] dl;
        int n, d, w;
        rst_n = 1'b0;
        req = '0; rxv = '1; idv = '0; dlcv = '0; datav = '0;
        repeat (3) @(negedge clk);
        check_idle(0, "rst1");
        check_idle(1, "rst4");
        rst_n = 1'b1;
        @(negedge clk);

        // All-ones ID: stuffing inside ID and after the control zeros
        start(0, 11'h7FF, 4'd0, 64'h0);
        scramble(0);
        do_frame(0, 11'h7FF, 4'd0, 64'h0, 1'b0, got);
        pat = '0;
        for (int i = 0; i < 22; i++) pat = {pat[20:0], (i < got.size()) ? got[i] : 1'b1};
        chk("id_stuff_pat", pat, 22'b0111110111110100000100);

        // Alternating pattern at 4 clks/bit, acknowledged
        start(1, 11'h555, 4'd8, 64'hAAAA_AAAA_AAAA_AAAA);
        scramble(1);
        do_frame(1, 11'h555, 4'd8, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, got);

        // DLC above 8 still sends exactly 8 bytes
        da = {$urandom, $urandom};
        start(0, 11'h2A3, 4'hF, da);
        scramble(0);
        do_frame(0, 11'h2A3, 4'hF, da, 1'b1, got);

        for (int r = 0; r < 6; r++) begin
            w = r % 2;
            ida = 11'($urandom);
            dl = 4'($urandom);
            da = {$urandom, $urandom};
            start(w, ida, dl, da);
            scramble(w);
            do_frame(w, ida, dl, da, r[1], got);
        end

        // Back-to-back with tx_req held; B's inputs presented while A is on the wire
        ida = 11'($urandom); idb = 11'($urandom);
        da = {$urandom, $urandom}; db = {$urandom, $urandom};
        start(0, ida, 4'd2, da);
        idv[0] = idb; dlcv[0] = 4'd5; datav[0] = db;
        do_frame(0, ida, 4'd2, da, 1'b1, got);
        @(negedge clk);
        chk("b2b_sof_busy", bsy[0], 1);
        chk("b2b_sof_tx", txo[0], 0);
        scramble(0);
        do_frame(0, idb, 4'd5, db, 1'b0, got);

        // Reset while a dominant data bit is on the wire
        start(1, 11'h123, 4'd8, 64'h0);
        scramble(1);
        n = 0;
        while (n < 400 && !(n >= 120 && txo[1] == 1'b0)) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_data", n < 400, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", txo[1], 1);
        chk("rst_mid_ready", rdy[1], 1);
        chk("rst_mid_busy", bsy[1], 0);
        chk("rst_mid_crc", crco[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        d = 0;
        repeat (12) begin
            @(negedge clk);
            if (dne[1] || txo[1] != 1'b1) d++;
        end
        chk("rst_quiet", d, 0);
        chk("rst_ready_after", rdy[1], 1);
        da = {$urandom, $urandom};
        start(1, 11'h3C5, 4'd3, da);
        scramble(1);
        do_frame(1, 11'h3C5, 4'd3, da, 1'b1, got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
